// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU ctrl codes,
// legal-code check and controller state encoding.
package alu_arb_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    function automatic logic is_legal(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker: a lone valid always wins; on a tie the
// requester that was not granted last wins. Purely combinational.
module alu_arb_rr (
    input  logic [1:0] valid,
    input  logic       last_gnt,
    output logic [1:0] grant
);

    always_comb begin
        grant    = '0;
        grant[0] = valid[0] & (~valid[1] | last_gnt);
        grant[1] = valid[1] & (~valid[0] | ~last_gnt);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE->ISSUE->RESP).
// Optional per-requester accept counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_ctrl_i,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_ctrl_i,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_illegal_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat0_o,
    output logic [15:0] stat1_o
`endif
);

    state_t     state;
    logic       last_gnt;
    logic       op_id;
    logic [1:0] grant;
    logic       accept;

    alu_arb_rr u_rr (
        .valid    ({req1_valid_i, req0_valid_i}),
        .last_gnt (last_gnt),
        .grant    (grant)
    );

    // Readies are gated by reset so nothing looks accepted while held in reset.
    assign accept       = rst_n && (state == IDLE) && (grant != '0);
    assign req0_ready_o = accept && grant[0];
    assign req1_ready_o = accept && grant[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_gnt      <= 1'b1;
            op_id         <= 1'b0;
            alu_ctrl_o    <= '0;
            alu_src1_o    <= '0;
            alu_src2_o    <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= 1'b0;
            rsp_result_o  <= '0;
            rsp_zero_o    <= 1'b0;
            rsp_illegal_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_id      <= grant[1];
                        alu_ctrl_o <= grant[1] ? req1_ctrl_i : req0_ctrl_i;
                        alu_src1_o <= grant[1] ? req1_src1_i : req0_src1_i;
                        alu_src2_o <= grant[1] ? req1_src2_i : req0_src2_i;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_id_o    <= op_id;
                    rsp_valid_o <= 1'b1;
                    if (is_legal(alu_ctrl_o)) begin
                        rsp_result_o  <= alu_result_i;
                        rsp_zero_o    <= alu_zero_i;
                        rsp_illegal_o <= 1'b0;
                    end else begin
                        rsp_result_o  <= '0;
                        rsp_zero_o    <= 1'b1;
                        rsp_illegal_o <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        last_gnt    <= rsp_id_o;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stat0_o <= '0;
            stat1_o <= '0;
        end else begin
            if (req0_ready_o && (stat0_o != '1)) stat0_o <= stat0_o + 16'd1;
            if (req1_ready_o && (stat1_o != '1)) stat1_o <= stat1_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; checks stat0_o/stat1_o when
// ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o, rsp_illegal_o;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat0_o, stat1_o;
`endif

    int tests = 0;
    int fails = 0;
    int model_last = 1;
    int acc0 = 0;
    int acc1 = 0;

    always #5 clk_i = ~clk_i;

    alu_arbiter dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_ctrl_i   (req0_ctrl_i),
        .req0_src1_i   (req0_src1_i),
        .req0_src2_i   (req0_src2_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_ctrl_i   (req1_ctrl_i),
        .req1_src1_i   (req1_src1_i),
        .req1_src2_i   (req1_src2_i),
        .alu_src1_o    (alu_src1_o),
        .alu_src2_o    (alu_src2_o),
        .alu_ctrl_o    (alu_ctrl_o),
        .alu_result_i  (alu_result_i),
        .alu_zero_i    (alu_zero_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_result_o  (rsp_result_o),
        .rsp_zero_o    (rsp_zero_o),
        .rsp_illegal_o (rsp_illegal_o)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat0_o       (stat0_o),
        .stat1_o       (stat1_o)
`endif
    );

    // Shared ALU stand-in; illegal codes give junk that must be ignored.
    always_comb begin
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
            4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
            4'b0111: alu_result_i = {31'd0, alu_src1_o < alu_src2_o};
            default: alu_result_i = 32'hDEAD_BEEF;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    // Reference: {illegal, zero, result}
    function automatic logic [33:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 1'b1, 32'd0};
        endcase
        return {1'b0, (r == 32'd0), r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " ready0"}, req0_ready_o, 0);
        chk({tag, " ready1"}, req1_ready_o, 0);
        chk({tag, " rsp_valid"}, rsp_valid_o, 0);
        chk({tag, " rsp_id"}, rsp_id_o, 0);
        chk({tag, " rsp_result"}, rsp_result_o, 0);
        chk({tag, " rsp_zero"}, rsp_zero_o, 0);
        chk({tag, " rsp_illegal"}, rsp_illegal_o, 0);
        chk({tag, " alu_src1"}, alu_src1_o, 0);
        chk({tag, " alu_src2"}, alu_src2_o, 0);
        chk({tag, " alu_ctrl"}, alu_ctrl_o, 0);
    endtask

    // One full transaction from IDLE back to IDLE; stall = cycles rsp_ready held low.
    task automatic run_op(input logic v0, input logic v1, input logic [3:0] c0, input logic [3:0] c1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int unsigned stall);
        int g;
        logic [3:0]  ec;
        logic [31:0] ea, eb;
        logic [33:0] er;
        g  = (v0 && v1) ? ((model_last == 0) ? 1 : 0) : (v0 ? 0 : 1);
        ec = (g == 1) ? c1 : c0;
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        er = ref_op(ec, ea, eb);
        req0_valid_i = v0; req0_ctrl_i = c0; req0_src1_i = a0; req0_src2_i = b0;
        req1_valid_i = v1; req1_ctrl_i = c1; req1_src1_i = a1; req1_src2_i = b1;
        rsp_ready_i  = (stall == 0);
        #1;
        chk("grant ready0", req0_ready_o, (g == 0));
        chk("grant ready1", req1_ready_o, (g == 1));
        if (g == 0) acc0++; else acc1++;
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        chk("issue ready0", req0_ready_o, 0);
        chk("issue ready1", req1_ready_o, 0);
        chk("issue rsp_valid", rsp_valid_o, 0);
        chk("issue alu_ctrl", alu_ctrl_o, ec);
        chk("issue alu_src1", alu_src1_o, ea);
        chk("issue alu_src2", alu_src2_o, eb);
        tick();
        for (int unsigned s = 0; s <= stall; s++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_id", rsp_id_o, g);
            chk("rsp_result", rsp_result_o, er[31:0]);
            chk("rsp_zero", rsp_zero_o, er[32]);
            chk("rsp_illegal", rsp_illegal_o, er[33]);
            if (s < stall) begin
                req0_valid_i = 1'b1;
                req1_valid_i = 1'b1;
                #1;
                chk("stall ready0", req0_ready_o, 0);
                chk("stall ready1", req1_ready_o, 0);
                tick();
            end
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        rsp_ready_i  = 1'b1;
        tick();
        chk("rsp_done valid", rsp_valid_o, 0);
        model_last  = g;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        logic [3:0] codes [7];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111, 4'b0101};

        rst_n = 1'b0;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        req0_ctrl_i = 4'd2; req1_ctrl_i = 4'd2;
        req0_src1_i = '0; req0_src2_i = '0; req1_src1_i = '0; req1_src2_i = '0;
        rsp_ready_i = 1'b1;
        #1;
        check_zero_outputs("reset");
        tick();
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single req0 ADD 5+7, ready held high throughout.
        run_op(1, 0, 4'b0010, 4'b0000, 32'd5, 32'd7, 32'd0, 32'd0, 0);

        // Both valid: SUB 3-3 vs OR 0xF0|0x0F, alternate grants.
        for (int i = 0; i < 4; i++)
            run_op(1, 1, 4'b0110, 4'b0001, 32'd3, 32'd3, 32'hF0, 32'h0F, 0);

        // Illegal ctrl from req1.
        run_op(0, 1, 4'b0000, 4'b1111, 32'd0, 32'd0, 32'h1234, 32'h5678, 0);

        // Backpressure 5 cycles, then the other requester wins the tie.
        run_op(1, 0, 4'b0111, 4'b0000, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 5);
        chk("post-stall last", model_last, 0);
        run_op(1, 1, 4'b0000, 4'b0010, 32'hFF00, 32'h0FF0, 32'hFFFF_FFFF, 32'd1, 0);

        // Reset during ISSUE discards the op.
        req0_valid_i = 1'b1; req0_ctrl_i = 4'b0010; req0_src1_i = 32'd9; req0_src2_i = 32'd1;
        rsp_ready_i = 1'b1;
        tick();
        req0_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        model_last = 1; acc0 = 0; acc1 = 0;
        tick();
        rst_n = 1'b1;
        rsp_ready_i = 1'b0;
        tick();
        chk("after reset rsp_valid", rsp_valid_o, 0);
        run_op(1, 1, 4'b0010, 4'b0010, 32'd1, 32'd2, 32'd3, 32'd4, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run_op(v[0], v[1], codes[$urandom_range(0, 6)], codes[$urandom_range(0, 6)],
                   $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   $urandom, $urandom, $urandom_range(0, 2));
        end

`ifdef ALU_ARB_STATS_EN
        chk("stat0", {16'd0, stat0_o}, acc0);
        chk("stat1", {16'd0, stat1_o}, acc1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester controller that shares one combinational ALU (ctrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111) between requesters. Accepts operations over valid/ready, grants round-robin, drives captured operands to the ALU for one cycle, and returns the registered result with requester ID over a valid/ready response channel. Sits between issue logic and the shared ALU instance.

## Interface
- No parameters; data width fixed at 32, ctrl width 4.
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid_i / req1_valid_i  in  1  requester k has an operation pending
- req0_ready_o / req1_ready_o  out  1  operation from requester k accepted this cycle
- req0_ctrl_i / req1_ctrl_i  in  4  ALU ctrl code
- req0_src1_i, req0_src2_i / req1_src1_i, req1_src2_i  in  32  operands
- alu_src1_o, alu_src2_o  out  32  operands to ALU
- alu_ctrl_o  out  4  ctrl code to ALU
- alu_result_i  in  32  ALU result (combinational from alu_* outputs)
- alu_zero_i  in  1  ALU zero flag
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  consumer takes response
- rsp_id_o  out  1  requester of this response (0/1)
- rsp_result_o  out  32  result
- rsp_zero_o  out  1  zero flag
- rsp_illegal_o  out  1  ctrl code was not one of the five legal codes

## Operation
- FSM states IDLE, ISSUE, RESP; reset state IDLE.
- IDLE: if any req valid, pick one via round-robin (priority to requester not granted last); assert that requester's ready combinationally; on the clock edge capture ctrl/src1/src2/id into op registers, go ISSUE. No valid: stay IDLE.
- Only one ready high at a time; ready never high outside IDLE.
- ISSUE: alu_* outputs reflect op registers; capture alu_result_i/alu_zero_i into response registers, rsp_illegal_o=0; go RESP. Illegal ctrl: result 0, zero 1, illegal 1, ALU output ignored; same timing.
- RESP: rsp_valid_o=1, all rsp_* stable until rsp_ready_i sampled high; then update last-granted = rsp_id_o, go IDLE.
- rsp_ready_i asserted early (IDLE/ISSUE) has no effect.
- Round-robin: both valid -> alternate; single valid -> that one wins regardless of history.
- Reset: last-granted = 1 (req0 wins first tie); op registers, alu_*, rsp_* outputs all 0; readies 0; rsp_valid_o 0.
- Reset mid-operation discards in-flight op; no response emitted.
- SLT is unsigned compare, matching the ALU; controller does no arithmetic.

## Timing
- Accept in cycle N (ready & valid) -> rsp_valid_o high from cycle N+2.
- Max throughput: one op per 3 cycles with rsp_ready_i tied high.
- Backpressure: each stalled RESP cycle adds one cycle; no request accepted while RESP held.
- alu_* outputs registered (no comb path from req inputs to ALU); readies are comb from valids and state.

## Configuration
- ALU_ARB_STATS_EN defined: adds outputs stat0_o, stat1_o (16 bits each), counting accepted requests per requester; saturate at 0xFFFF; reset 0; increment on accept edge.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package alu_arb_pkg: ctrl code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), legal-code function, FSM state enum.
- Sub-module alu_arb_rr: 2-way round-robin picker (valids, last-granted in; one-hot grant out), purely combinational.

## Test plan
- req0 ADD 5+7, rsp_ready high -> ready0 at N, rsp at N+2: id 0, result 12, zero 0, illegal 0.
- Both valid continuously, req0 SUB 3-3, req1 OR 0xF0|0x0F -> grants 0,1,0,1; rsp id0 result 0 zero 1; id1 result 0xFF.
- req1 ctrl 4'b1111 -> rsp result 0, zero 1, illegal 1; ALU result ignored.
- rsp_ready low 5 cycles in RESP -> rsp_* stable, both readies 0; release -> next grant to other requester.
- rst_n pulsed low during ISSUE -> rsp_valid_o stays 0, all outputs 0 immediately; after release req0 wins tie.
- With ALU_ARB_STATS_EN: 3 req0 + 2 req1 accepts -> stat0_o 3, stat1_o 2; preload near max -> holds 0xFFFF.
